// File: rtl/tdes_pkg.sv
// tdes_pkg: shared definitions for the two-key Triple-DES decryptor.
// Holds the FSM state enum, the DES permutation tables (IP, FP, E, P, PC-2),
// the eight S-boxes, the key-rotation table and small helpers that apply them.
// Table entries use DES numbering: bit 1 is the MSB of the source word.
package tdes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Each box is stored row-major: entry index = row*16 + col.
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  localparam int SHIFT_TBL [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_TBL[j])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - FP_TBL[j])];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[5'(32 - E_TBL[j])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int j = 0; j < 32; j++) y[5'(31 - j)] = x[5'(32 - P_TBL[j])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - PC2_TBL[j])];
    return y;
  endfunction

  // Row is formed from the outer bits of each 6-bit group, column from the inner four.
  function automatic logic [31:0] sbox_sub(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  six;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      six = x[6'(47 - 6 * i) -: 6];
      y[5'(31 - 4 * i) -: 4] = 4'(SBOX[3'(i)][{six[5], six[0], six[4:1]}]);
    end
    return y;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] v, input int n);
    return (n == 2) ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] v, input int n);
    return (n == 2) ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

endpackage

// File: rtl/des_round.sv
// des_round: one combinational DES Feistel round.
// Ports:
//   l, r    - current 32-bit halves
//   subkey  - 48-bit round key
//   l_next  - next left half (= r)
//   r_next  - next right half (= l ^ f(r, subkey))
module des_round
  import tdes_pkg::*;
(
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [47:0] subkey,
  output logic [31:0] l_next,
  output logic [31:0] r_next
);

  logic [47:0] mixed;

  assign mixed  = e_expand(r) ^ subkey;
  assign l_next = r;
  assign r_next = l ^ p_perm(sbox_sub(mixed));

endmodule

// File: rtl/tdes_decrypt_seq.sv
// tdes_decrypt_seq: iterative two-key Triple-DES decryptor, one Feistel round
// per clock: plaintext = D_key1(E_key2(D_key1(intext))), 48 rounds per block.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid / in_ready - input handshake for intext, key1, key2
//   key1, key2          - 56-bit post-PC-1 keys (C in [55:28], D in [27:0])
//   intext              - 64-bit ciphertext block
//   out_valid/out_ready - output handshake for password
//   password            - 64-bit plaintext, held until the next result
module tdes_decrypt_seq
  import tdes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [55:0] key1,
  input  logic [55:0] key2,
  input  logic [63:0] intext,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] password
);

  state_t      state_q, state_d;
  logic [31:0] l_q, r_q, l_new, r_new;
  logic [27:0] c_q, d_q;
  logic [55:0] k1_q, k2_q;
  logic [3:0]  round_q;
  logic [1:0]  pass_q;

  logic        accept, last_round, last_pass, is_enc;
  int          shift_amt;
  logic [55:0] cd_next;
  logic [47:0] subkey;
  logic [63:0] pass_out;

  assign accept     = in_valid && in_ready;
  assign last_round = (round_q == 4'd15);
  assign last_pass  = (pass_q == 2'd2);
  assign is_enc     = (pass_q == 2'd1);

  // Key schedule. Encrypt rotates left before PC-2; decrypt starts from the
  // unrotated key (which equals C16/D16) and rotates right after PC-2.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    shift_amt = 1;
    cd_next   = {c_q, d_q};
    subkey    = '0;
    if (is_enc) begin
      shift_amt = SHIFT_TBL[round_q];
      cd_next   = {rotl28(c_q, shift_amt), rotl28(d_q, shift_amt)};
      subkey    = pc2_perm(cd_next);
    end else begin
      shift_amt = SHIFT_TBL[4'd15 - round_q];
      cd_next   = {rotr28(c_q, shift_amt), rotr28(d_q, shift_amt)};
      subkey    = pc2_perm({c_q, d_q});
    end
  end

  des_round u_round (
    .l      (l_q),
    .r      (r_q),
    .subkey (subkey),
    .l_next (l_new),
    .r_next (r_new)
  );

  // Pass result after the 16th round: swap halves, then FP.
  assign pass_out = fp_perm({r_new, l_new});

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)                state_d = RUN;
      RUN:     if (last_round && last_pass) state_d = DONE;
      DONE:    if (out_ready)               state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath, key schedule registers and pass/round counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      k1_q     <= '0;
      k2_q     <= '0;
      round_q  <= '0;
      pass_q   <= '0;
      password <= '0;
    end else if (accept) begin
      k1_q       <= key1;
      k2_q       <= key2;
      {l_q, r_q} <= ip_perm(intext);
      {c_q, d_q} <= key1;
      round_q    <= '0;
      pass_q     <= '0;
    end else if (state_q == RUN) begin
      if (!last_round) begin
        {l_q, r_q} <= {l_new, r_new};
        {c_q, d_q} <= cd_next;
        round_q    <= round_q + 4'd1;
      end else if (!last_pass) begin
        // FP/IP between passes is folded into this same cycle.
        {l_q, r_q} <= ip_perm(pass_out);
        {c_q, d_q} <= (pass_q == 2'd0) ? k2_q : k1_q;
        round_q    <= '0;
        pass_q     <= pass_q + 2'd1;
      end else begin
        // Final round of pass 2: counters hold at 15/2 until the next block.
        password <= pass_out;
      end
    end
  end

endmodule

// File: tb/tb_tdes_decrypt_seq.sv
// tb_tdes_decrypt_seq: randomized scoreboard bench for tdes_decrypt_seq.
// A textbook DES model (forward key schedule, subkeys reversed for decrypt)
// produces expected plaintexts; a negedge monitor pops and compares them.
module tb_tdes_decrypt_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [55:0] key1 = '0;
  logic [55:0] key2 = '0;
  logic [63:0] intext = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] password;

  tdes_decrypt_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key1      (key1),
    .key2      (key2),
    .intext    (intext),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .password  (password)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IP [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,
    59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  localparam int M_FP [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,
    35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  localparam int M_E [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
    16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int M_P [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int M_PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int M_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int M_S [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // sel: 0=IP 1=FP 2=E 3=P 4=PC2
  function automatic int tbl_at(input int sel, input int j);
    case (sel)
      0:       return M_IP[j];
      1:       return M_FP[j];
      2:       return M_E[j];
      3:       return M_P[j];
      default: return M_PC2[j];
    endcase
  endfunction

  // Permute a right-justified w_in-bit value; result is right-justified.
  function automatic logic [63:0] m_perm(input logic [63:0] x, input int w_in, input int sel);
    logic [63:0] y;
    int w_out;
    y = '0;
    w_out = (sel <= 1) ? 64 : (sel == 3) ? 32 : 48;
    for (int j = 0; j < w_out; j++) y[6'(w_out - 1 - j)] = x[6'(w_in - tbl_at(sel, j))];
    return y;
  endfunction

  function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
    logic [63:0] e, p;
    logic [47:0] x;
    logic [31:0] s;
    int six, row, col;
    e = m_perm({32'h0, r}, 32, 2);
    x = e[47:0] ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = int'((x >> (42 - 6 * b)) & 48'h3F);
      row = ((six >> 4) & 2) | (six & 1);
      col = (six >> 1) & 15;
      s   = (s << 4) | 32'(M_S[b][row * 16 + col]);
    end
    p = m_perm({32'h0, s}, 32, 3);
    return p[31:0];
  endfunction

  function automatic logic [63:0] m_des(input logic [63:0] blk, input logic [55:0] k, input bit decrypt);
    logic [47:0] ks [16];
    logic [27:0] c, d;
    logic [63:0] x, sk;
    logic [31:0] l, r, t;
    c = k[55:28];
    d = k[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < M_SH[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      sk    = m_perm({8'h0, c, d}, 56, 4);
      ks[i] = sk[47:0];
    end
    x = m_perm(blk, 64, 0);
    l = x[63:32];
    r = x[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ m_f(r, decrypt ? ks[15 - i] : ks[i]);
      l = t;
    end
    return m_perm({r, l}, 64, 1);
  endfunction

  function automatic logic [63:0] model_dec3(input logic [63:0] c, input logic [55:0] k1, input logic [55:0] k2);
    return m_des(m_des(m_des(c, k1, 1'b1), k2, 1'b0), k1, 1'b1);
  endfunction

  function automatic logic [63:0] model_enc3(input logic [63:0] p, input logic [55:0] k1, input logic [55:0] k2);
    return m_des(m_des(m_des(p, k1, 1'b0), k2, 1'b1), k1, 1'b0);
  endfunction

  // ---------------- scoreboard + monitor ----------------
  logic [63:0] exp_q [$];
  int          acc_q [$];
  int          last_acc = 0;
  bit          prev_ov = 1'b0, prev_hs = 1'b0, rand_or = 1'b0;
  logic [63:0] held_pw = '0, last_pw = '0;

  always @(negedge clk) begin
    logic [63:0] exp_v;
    int          acc_v;
    if (rst) begin
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) begin
        check("in_ready_after_release", 64'(in_ready), 64'd1);
        check("out_valid_after_release", 64'(out_valid), 64'd0);
        check("password_retained_idle", password, last_pw);
      end
      prev_hs = 1'b0;
      if (out_valid) begin
        if (!prev_ov) begin
          check("output_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            acc_v = acc_q.pop_front();
            check("password", password, exp_v);
            check("latency_cycles", 64'(cyc - acc_v), 64'd48);
          end
          held_pw = password;
        end else begin
          check("password_hold", password, held_pw);
          check("in_ready_low_in_done", 64'(in_ready), 64'd0);
        end
        if (out_ready) begin
          prev_hs = 1'b1;
          last_pw = password;
        end
      end
      prev_ov = out_valid;
    end
  end

  // Random consumer backpressure when enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_or) out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] blk, input logic [55:0] k1, input logic [55:0] k2,
                      input logic [63:0] expv);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    intext   = blk;
    key1     = k1;
    key2     = k2;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        exp_q.push_back(expv);
        acc_q.push_back(cyc);
        last_acc = cyc;
        accepted = 1'b1;
      end
    end
    check("accept_within_bound", 64'(accepted), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && !(exp_q.size() == 0 && in_ready); i++) @(negedge clk);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    tick(1);
  endtask

  function automatic logic [55:0] rnd56();
    return 56'({$urandom(), $urandom()});
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [55:0] k1, k2;
    logic [63:0] blk, p;
    int r0, prev_acc;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_password", password, 64'h0);
    tick(3);
    rst = 1'b0;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    r0 = cyc;

    // Single-DES equivalence vector; also checks acceptance on the first edge.
    send(64'h85E813540F0AB405, 56'hF0CCAAF556678F, 56'hF0CCAAF556678F, 64'h0123456789ABCDEF);
    check("first_accept_edge", 64'(last_acc - r0), 64'd1);
    drain();

    // Round trips from known and random plaintexts under distinct keys.
    for (int i = 0; i < 3; i++) begin
      k1 = rnd56();
      k2 = rnd56() ^ 56'h1;
      if (k2 == k1) k2 = ~k1;
      p  = (i == 0) ? 64'h0123456789ABCDEF : rnd64();
      send(model_enc3(p, k1, k2), k1, k2, p);
      drain();
    end

    // Backpressure: hold out_ready low for 10 cycles after out_valid.
    out_ready = 1'b0;
    k1 = rnd56(); k2 = rnd56(); blk = rnd64();
    send(blk, k1, k2, model_dec3(blk, k1, k2));
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    tick(10);
    out_ready = 1'b1;
    drain();

    // Input stability: inputs change mid-RUN and in_valid is asserted in RUN.
    k1 = rnd56(); k2 = rnd56(); blk = rnd64();
    send(blk, k1, k2, model_dec3(blk, k1, k2));
    tick(5);
    intext   = ~blk;
    key1     = rnd56();
    key2     = rnd56();
    in_valid = 1'b1;
    tick(1);
    check("in_ready_low_in_run", 64'(in_ready), 64'd0);
    tick(38);
    in_valid = 1'b0;
    drain();

    // Mid-run reset at round 20, then a fresh block.
    k1 = rnd56(); k2 = rnd56(); blk = rnd64();
    send(blk, k1, k2, model_dec3(blk, k1, k2));
    tick(20);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
    check("midrun_rst_password", password, 64'h0);
    check("midrun_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    acc_q.delete();
    last_pw = '0;
    tick(2);
    rst = 1'b0;
    k1 = rnd56(); k2 = rnd56(); blk = rnd64();
    send(blk, k1, k2, model_dec3(blk, k1, k2));
    drain();

    // Back-to-back with out_ready high: acceptances 50 cycles apart.
    out_ready = 1'b1;
    prev_acc  = 0;
    for (int i = 0; i < 3; i++) begin
      k1 = rnd56(); k2 = rnd56(); blk = rnd64();
      send(blk, k1, k2, model_dec3(blk, k1, k2));
      if (i > 0) check("back_to_back_spacing", 64'(last_acc - prev_acc), 64'd50);
      prev_acc = last_acc;
    end
    drain();

    // Random blocks with random consumer backpressure.
    rand_or = 1'b1;
    for (int i = 0; i < 6; i++) begin
      k1 = rnd56(); k2 = rnd56(); blk = rnd64();
      send(blk, k1, k2, model_dec3(blk, k1, k2));
    end
    drain();
    rand_or = 1'b0;
    tick(1);
    out_ready = 1'b1;

    // Quiet period: any spurious output is flagged by the monitor.
    tick(60);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
